// File: rtl/cpu_mem_access_unit.sv
// ---------------------------------------------------------------------------
// cpu_mem_access_unit
//
// Breaks one CPU memory access of 1..MAX_BYTES bytes into single-byte bus
// cycles. Bytes go out in ascending order starting at base_addr. The address
// of each byte is base_addr+k, optionally wrapped within a bank (low 16 bits)
// or a page (low 8 bits). Read data returns one cycle after each request and
// is assembled little-endian into rdata. All outputs are registered.
//
// Optional feature macro: CPU_MAU_WRAP_MODES_EN
//   defined   : wrap_mode selects linear / bank / page address wrapping
//   undefined : wrap_mode is ignored and every transfer is linear
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   enable      1 = advance, 0 = freeze every register (bus slave shares it)
//   start       transfer request, only looked at in IDLE
//   rd_wr       0 = read, 1 = write
//   num_bytes   transfer length, legal 1..MAX_BYTES
//   wrap_mode   0/3 linear, 1 bank, 2 page
//   base_addr   address of byte 0
//   wdata       write bytes, byte k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_in     bus read data, valid the cycle after a read request
//   busy        transfer in progress (low again in the done cycle)
//   done        one-cycle completion pulse
//   err         one-cycle pulse after a start with an illegal length
//   rdata       assembled read bytes, unread bytes zero
//   req_rdwr    bus request valid
//   which_rdwr  bus direction, 0 = read, 1 = write
//   addr        bus address
//   data_out    bus write data
// ---------------------------------------------------------------------------
module cpu_mem_access_unit #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BYTES  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            start,
    input  logic                            rd_wr,
    input  logic [1:0]                      num_bytes,
    input  logic [1:0]                      wrap_mode,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [MAX_BYTES*DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [MAX_BYTES*DATA_WIDTH-1:0] rdata,
    output logic                            req_rdwr,
    output logic                            which_rdwr,
    output logic [ADDR_WIDTH-1:0]           addr,
    output logic [DATA_WIDTH-1:0]           data_out
);

    localparam int   IDX_W = $clog2(MAX_BYTES + 1);
    localparam logic DIR_READ = 1'b0;

    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_t;

    state_t                          state_reg, state_next;
    logic [IDX_W-1:0]                idx_reg, idx_next;     // byte currently on the bus
    logic [IDX_W-1:0]                last_reg, last_next;   // index of final byte
    logic                            dir_reg, dir_next;
    logic [ADDR_WIDTH-1:0]           base_reg, base_next;
    logic [MAX_BYTES*DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [1:0]                      mode_reg, mode_next;

    logic                            busy_reg, busy_next;
    logic                            done_reg, done_next;
    logic                            err_reg, err_next;
    logic [MAX_BYTES*DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                            req_reg, req_next;
    logic                            which_reg, which_next;
    logic [ADDR_WIDTH-1:0]           addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]           dout_reg, dout_next;

    // Control strobes from the FSM to the datapath
    logic                            load_byte;   // present byte idx_next on the bus
    logic                            clr_rdata;
    logic                            cap_en;
    logic [IDX_W-1:0]                cap_idx;

    // In IDLE the first byte comes straight from the request inputs;
    // afterwards from the latched copies.
    logic                            sel_idle;
    logic                            dir_sel;
    logic [ADDR_WIDTH-1:0]           base_sel;
    logic [MAX_BYTES*DATA_WIDTH-1:0] wdata_sel;
    logic [1:0]                      mode_sel;
    logic [ADDR_WIDTH-1:0]           addr_sum;
    logic [ADDR_WIDTH-1:0]           addr_wrapped;
    logic                            len_legal;

    assign sel_idle  = (state_reg == IDLE);
    assign dir_sel   = sel_idle ? rd_wr     : dir_reg;
    assign base_sel  = sel_idle ? base_addr : base_reg;
    assign wdata_sel = sel_idle ? wdata     : wdata_reg;
    assign mode_sel  = sel_idle ? wrap_mode : mode_reg;
    assign len_legal = (num_bytes != 2'd0) && (32'(num_bytes) <= MAX_BYTES);
    assign addr_sum  = base_sel + {{(ADDR_WIDTH-IDX_W){1'b0}}, idx_next};

`ifdef CPU_MAU_WRAP_MODES_EN
    // Bank/page wrapping keeps the upper address bits of base_addr and lets
    // only the low 16 / 8 bits roll over.
    always_comb begin
        addr_wrapped = addr_sum;
        case (mode_sel)
            2'd1:    addr_wrapped = {base_sel[ADDR_WIDTH-1:16], addr_sum[15:0]};
            2'd2:    addr_wrapped = {base_sel[ADDR_WIDTH-1:8],  addr_sum[7:0]};
            default: addr_wrapped = addr_sum;
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode  = ^mode_sel;
    assign addr_wrapped = addr_sum;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        dir_next   = dir_reg;
        base_next  = base_reg;
        wdata_next = wdata_reg;
        mode_next  = mode_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        req_next   = req_reg;
        which_next = which_reg;
        addr_next  = addr_reg;
        dout_next  = dout_reg;
        load_byte  = 1'b0;
        clr_rdata  = 1'b0;
        cap_en     = 1'b0;
        cap_idx    = idx_reg - IDX_W'(1);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len_legal) begin
                        dir_next   = rd_wr;
                        last_next  = IDX_W'(num_bytes - 2'd1);
                        base_next  = base_addr;
                        wdata_next = wdata;
                        mode_next  = wrap_mode;
                        idx_next   = '0;
                        busy_next  = 1'b1;
                        clr_rdata  = 1'b1;
                        load_byte  = 1'b1;
                        state_next = XFER;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            XFER: begin
                // Read data for the previous byte is on data_in this cycle.
                cap_en = (dir_reg == DIR_READ) && (idx_reg != '0);
                if (idx_reg == last_reg) begin
                    req_next  = 1'b0;
                    dout_next = '0;
                    if (dir_reg == DIR_READ) begin
                        // One more cycle to collect the final byte.
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = TAIL;
                    end else begin
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = DONE;
                    end
                end else begin
                    idx_next  = idx_reg + IDX_W'(1);
                    load_byte = 1'b1;
                end
            end
            TAIL: begin
                cap_en     = 1'b1;
                busy_next  = 1'b0;
                done_next  = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (load_byte) begin
            req_next   = 1'b1;
            which_next = dir_sel;
            addr_next  = addr_wrapped;
            dout_next  = (dir_sel == DIR_READ) ? '0
                                               : wdata_sel[idx_next*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Per-lane read capture: cleared on accept, loaded when its byte returns.
    for (genvar gi = 0; gi < MAX_BYTES; gi++) begin : g_rlane
        assign rdata_next[gi*DATA_WIDTH +: DATA_WIDTH] =
            clr_rdata                           ? '0 :
            (cap_en && (cap_idx == IDX_W'(gi))) ? data_in :
                                                  rdata_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else if (enable) begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg   <= '0;
            last_reg  <= '0;
            dir_reg   <= DIR_READ;
            base_reg  <= '0;
            wdata_reg <= '0;
            mode_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            req_reg   <= 1'b0;
            which_reg <= DIR_READ;
            addr_reg  <= '0;
            dout_reg  <= '0;
        end else if (enable) begin
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            dir_reg   <= dir_next;
            base_reg  <= base_next;
            wdata_reg <= wdata_next;
            mode_reg  <= mode_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            req_reg   <= req_next;
            which_reg <= which_next;
            addr_reg  <= addr_next;
            dout_reg  <= dout_next;
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign rdata      = rdata_reg;
    assign req_rdwr   = req_reg;
    assign which_rdwr = which_reg;
    assign addr       = addr_reg;
    assign data_out   = dout_reg;

endmodule

// File: tb/tb_cpu_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_access_unit
//
// Table of directed transfers with hand-computed bus addresses, write bytes,
// read results and done-cycle numbers, plus hand-written sequences for reset,
// illegal length, start-while-busy, enable freeze and reset mid-transfer.
// Cycle 0 is the cycle start is driven; cycle k+1 shows byte k.
// ---------------------------------------------------------------------------
module tb_cpu_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        start;
    logic        rd_wr;
    logic [1:0]  num_bytes;
    logic [1:0]  wrap_mode;
    logic [23:0] base_addr;
    logic [23:0] wdata;
    logic [7:0]  data_in;
    logic        busy, done, err, req_rdwr, which_rdwr;
    logic [23:0] rdata;
    logic [23:0] addr;
    logic [7:0]  data_out;

    int n_checks = 0;
    int n_err    = 0;
    int bus_cnt  = 0;

    cpu_mem_access_unit dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .rd_wr(rd_wr),
        .num_bytes(num_bytes), .wrap_mode(wrap_mode), .base_addr(base_addr),
        .wdata(wdata), .data_in(data_in), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .req_rdwr(req_rdwr), .which_rdwr(which_rdwr),
        .addr(addr), .data_out(data_out)
    );

    always #5 clk = ~clk;

    // Bus memory contents used by the read vectors
    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        case (a)
            24'h01FFFF: mem_rd = 8'hAA;
            24'h010000: mem_rd = 8'hBB;
            24'h020000: mem_rd = 8'hCC;
            24'h1234FF: mem_rd = 8'h11;
            24'h123400: mem_rd = 8'h22;
            24'h123500: mem_rd = 8'h33;
            default:    mem_rd = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Bus slave: read data one cycle after the request, gated by enable
    always @(posedge clk or negedge rst) begin
        if (!rst) data_in <= 8'h00;
        else if (enable) data_in <= (req_rdwr && !which_rdwr) ? mem_rd(addr) : 8'h00;
    end

    always @(posedge clk) begin
        if (rst && enable && req_rdwr) bus_cnt <= bus_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic [1:0]  n;
        logic [1:0]  mode;
        logic [23:0] base;
        logic [23:0] wd;
        logic [23:0] ea0, ea1, ea2;
        logic [23:0] erd;
        int          edone;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic [1:0] n, input logic [1:0] mode,
                                input logic [23:0] base, input logic [23:0] wd,
                                input logic [23:0] a0, input logic [23:0] a1,
                                input logic [23:0] a2, input logic [23:0] erd, input int ed);
        vec_t v;
        v.rd = rd; v.n = n; v.mode = mode; v.base = base; v.wd = wd;
        v.ea0 = a0; v.ea1 = a1; v.ea2 = a2; v.erd = erd; v.edone = ed;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [23:0] ea;
        logic [23:0] wtmp;
        int          cyc;
        start = 1'b1; rd_wr = v.rd; num_bytes = v.n; wrap_mode = v.mode;
        base_addr = v.base; wdata = v.wd;
        tick();
        start = 1'b0;
        for (int k = 0; k < int'(v.n); k++) begin
            ea = (k == 0) ? v.ea0 : (k == 1) ? v.ea1 : v.ea2;
            check($sformatf("v%0d_req%0d", id, k), {31'd0, req_rdwr}, 32'd1);
            check($sformatf("v%0d_busy%0d", id, k), {31'd0, busy}, 32'd1);
            check($sformatf("v%0d_dir%0d", id, k), {31'd0, which_rdwr}, {31'd0, v.rd});
            check($sformatf("v%0d_addr%0d", id, k), {8'd0, addr}, {8'd0, ea});
            if (v.rd) begin
                wtmp = v.wd >> (8 * k);
                check($sformatf("v%0d_wbyte%0d", id, k), {24'd0, data_out}, {24'd0, wtmp[7:0]});
            end
            tick();
        end
        cyc = int'(v.n) + 1;
        while (done !== 1'b1 && cyc < 12) begin
            check($sformatf("v%0d_tail_req", id), {31'd0, req_rdwr}, 32'd0);
            tick();
            cyc++;
        end
        check($sformatf("v%0d_done_cycle", id), cyc, v.edone);
        check($sformatf("v%0d_done_busy", id), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d_done_req", id), {31'd0, req_rdwr}, 32'd0);
        check($sformatf("v%0d_rdata", id), {8'd0, rdata}, {8'd0, v.erd});
        tick();
        check($sformatf("v%0d_done_gone", id), {31'd0, done}, 32'd0);
        check($sformatf("v%0d_rdata_hold", id), {8'd0, rdata}, {8'd0, v.erd});
        $display("vec %0d: %s n=%0d mode=%0d base=%h done_cycle=%0d rdata=%h",
                 id, v.rd ? "write" : "read", v.n, v.mode, v.base, cyc, rdata);
    endtask

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int bc0;
        // Expected addresses/data for the wrap modes depend on the build option
`ifdef CPU_MAU_WRAP_MODES_EN
        vecs[2] = mk(1'b0, 2'd2, 2'd1, 24'h01FFFF, 24'h0, 24'h01FFFF, 24'h010000, 24'h0, 24'h00BBAA, 4);
        vecs[5] = mk(1'b0, 2'd2, 2'd2, 24'h1234FF, 24'h0, 24'h1234FF, 24'h123400, 24'h0, 24'h002211, 4);
        vecs[8] = mk(1'b1, 2'd3, 2'd2, 24'h0000FE, 24'h030201, 24'h0000FE, 24'h0000FF, 24'h000000, 24'h0, 4);
`else
        vecs[2] = mk(1'b0, 2'd2, 2'd1, 24'h01FFFF, 24'h0, 24'h01FFFF, 24'h020000, 24'h0, 24'h00CCAA, 4);
        vecs[5] = mk(1'b0, 2'd2, 2'd2, 24'h1234FF, 24'h0, 24'h1234FF, 24'h123500, 24'h0, 24'h003311, 4);
        vecs[8] = mk(1'b1, 2'd3, 2'd2, 24'h0000FE, 24'h030201, 24'h0000FE, 24'h0000FF, 24'h000100, 24'h0, 4);
`endif
        vecs[0] = mk(1'b0, 2'd3, 2'd0, 24'hFFFFFE, 24'h0, 24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h5AA5A4, 5);
        vecs[1] = mk(1'b1, 2'd3, 2'd0, 24'h00F000, 24'h874512, 24'h00F000, 24'h00F001, 24'h00F002, 24'h0, 4);
        vecs[3] = mk(1'b0, 2'd2, 2'd0, 24'h01FFFF, 24'h0, 24'h01FFFF, 24'h020000, 24'h0, 24'h00CCAA, 4);
        vecs[4] = mk(1'b0, 2'd1, 2'd2, 24'h1234FF, 24'h0, 24'h1234FF, 24'h0, 24'h0, 24'h000011, 3);
        vecs[6] = mk(1'b1, 2'd1, 2'd3, 24'hFFFFFF, 24'h00009C, 24'hFFFFFF, 24'h0, 24'h0, 24'h0, 2);
        vecs[7] = mk(1'b1, 2'd2, 2'd0, 24'hFFFFFF, 24'h00BEEF, 24'hFFFFFF, 24'h000000, 24'h0, 24'h0, 3);

        rst = 1'b0; enable = 1'b1; start = 1'b0; rd_wr = 1'b0; num_bytes = 2'd0;
        wrap_mode = 2'd0; base_addr = 24'h0; wdata = 24'h0;
        tick(); tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_req", {31'd0, req_rdwr}, 32'd0);
        check("rst_dir", {31'd0, which_rdwr}, 32'd0);
        check("rst_addr", {8'd0, addr}, 32'd0);
        check("rst_dout", {24'd0, data_out}, 32'd0);
        check("rst_rdata", {8'd0, rdata}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Illegal length: err pulse, no bus activity
        bc0 = bus_cnt;
        start = 1'b1; rd_wr = 1'b0; num_bytes = 2'd0; base_addr = 24'h000100;
        tick();
        start = 1'b0;
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        check("err_req", {31'd0, req_rdwr}, 32'd0);
        tick();
        check("err_gone", {31'd0, err}, 32'd0);
        check("err_bus", bus_cnt - bc0, 32'd0);
        $display("illegal length start: err pulse seen");

        // Start held high while busy must not add bus cycles
        bc0 = bus_cnt;
        start = 1'b1; rd_wr = 1'b0; num_bytes = 2'd2; wrap_mode = 2'd0; base_addr = 24'h01FFFF;
        tick();
        rd_wr = 1'b1; num_bytes = 2'd3; base_addr = 24'h005000;
        tick();
        tick();
        start = 1'b0;
        tick();
        check("busy_start_done", {31'd0, done}, 32'd1);
        check("busy_start_rdata", {8'd0, rdata}, 32'h0000CCAA);
        tick(); tick(); tick();
        check("busy_start_bus", bus_cnt - bc0, 32'd2);
        check("busy_start_idle", {31'd0, busy}, 32'd0);
        $display("start while busy: bus cycles=%0d", bus_cnt - bc0);

        // Enable low freezes mid-transfer
        start = 1'b1; rd_wr = 1'b1; num_bytes = 2'd3; base_addr = 24'h000100; wdata = 24'h332211;
        tick();
        start = 1'b0;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_addr", {8'd0, addr}, 32'h00000101);
            check("frz_req", {31'd0, req_rdwr}, 32'd1);
            check("frz_dout", {24'd0, data_out}, 32'h22);
        end
        enable = 1'b1;
        tick();
        check("frz_resume_addr", {8'd0, addr}, 32'h00000102);
        tick();
        check("frz_done", {31'd0, done}, 32'd1);
        tick();
        $display("enable freeze: transfer resumed and completed");

        // Reset asserted during cycle 2 of a 3-byte write
        start = 1'b1; rd_wr = 1'b1; num_bytes = 2'd3; base_addr = 24'h00F000; wdata = 24'h874512;
        tick();
        start = 1'b0;
        tick();
        check("mid_pre_addr", {8'd0, addr}, 32'h0000F001);
        rst = 1'b0;
        #1;
        check("mid_req", {31'd0, req_rdwr}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_addr", {8'd0, addr}, 32'd0);
        tick();
        check("mid_done_rst", {31'd0, done}, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_no_done", {31'd0, done}, 32'd0);
            check("mid_no_req", {31'd0, req_rdwr}, 32'd0);
        end
        $display("reset mid-transfer: abandoned without done");
        run_vec(vecs[1], 99);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
